// File: rtl/dc_1_bank_requester.sv
// Bank requester: splits a 128-bit line command into Rows 36-bit bank requests
// and, for reads, gathers the in-order bank acks back into one line response.
`ifndef WAY_BITS
`define WAY_BITS 2
`endif

module dc_1_bank_requester #(
    parameter int Width = 36,
    parameter int Rows  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_retry,
    input  logic                 cmd_write,
    input  logic [28:0]          cmd_addr,
    input  logic [`WAY_BITS-1:0] cmd_way,
    input  logic [127:0]         cmd_wdata,
    input  logic [15:0]          cmd_wmask,
    output logic                 req_valid,
    input  logic                 req_retry,
    output logic                 write,
    output logic [28:0]          req_addr,
    output logic [`WAY_BITS-1:0] way_no,
    output logic [1:0]           row_even_odd,
    output logic [Width-1:0]     req_data,
    input  logic                 ack_valid,
    output logic                 ack_retry,
    input  logic [Width-1:0]     ack_data,
    output logic                 rsp_valid,
    input  logic                 rsp_retry,
    output logic [127:0]         rsp_data
);
    localparam int DW = Width - 4;
    localparam int RW = $clog2(Rows);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                      state, state_nxt;
    logic [28:0]                 addr_q;
    logic [`WAY_BITS-1:0]        way_q;
    logic                        write_q;
    logic [Rows-1:0][DW-1:0]     wdata_q;
    logic [Rows-1:0][3:0]        wmask_q;
    logic [Rows-1:0][DW-1:0]     line_q;
    logic [2:0]                  issue_cnt, ack_cnt, ack_total;
    logic [RW-1:0]               issue_row, ack_row;
    logic                        cmd_xfer, req_xfer, rsp_xfer, ack_take, last_issue;
    logic                        ack_unused;

    assign issue_row  = issue_cnt[RW-1:0];
    assign ack_row    = ack_cnt[RW-1:0];
    assign cmd_xfer   = cmd_valid && (state == IDLE);
    assign req_xfer   = (state == ISSUE) && !req_retry;
    assign rsp_xfer   = (state == RESP) && !rsp_retry;
    assign last_issue = req_xfer && (issue_cnt == 3'(Rows - 1));
    // Acks are only meaningful while a read is in flight; anything else is dropped.
    assign ack_take   = ack_valid && !write_q && ((state == ISSUE) || (state == DRAIN))
                        && (ack_cnt < 3'(Rows));
    assign ack_total  = ack_cnt + {2'b0, ack_take};
    assign ack_unused = ^ack_data[Width-1:DW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_xfer) state_nxt = ISSUE;
            ISSUE: if (last_issue) begin
                       if (write_q)                    state_nxt = IDLE;
                       else if (ack_total < 3'(Rows)) state_nxt = DRAIN;
                       else                           state_nxt = RESP;
                   end
            DRAIN: if (ack_take && (ack_cnt == 3'(Rows - 1))) state_nxt = RESP;
            RESP:  if (rsp_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_retry    = (state != IDLE);
        req_valid    = (state == ISSUE);
        rsp_valid    = (state == RESP);
        ack_retry    = (state == RESP);
        write        = req_valid && write_q;
        req_addr     = req_valid ? addr_q : 29'h0;
        way_no       = req_valid ? way_q : '0;
        row_even_odd = req_valid ? issue_cnt[1:0] : 2'b0;
        req_data     = write ? {wmask_q[issue_row], wdata_q[issue_row]} : '0;
        rsp_data     = line_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            way_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            issue_cnt <= '0;
            ack_cnt   <= '0;
            line_q    <= '0;
        end else begin
            if (cmd_xfer) begin
                addr_q    <= cmd_addr;
                way_q     <= cmd_way;
                write_q   <= cmd_write;
                wdata_q   <= cmd_wdata;
                wmask_q   <= cmd_wmask;
                issue_cnt <= '0;
                ack_cnt   <= '0;
            end else begin
                if (req_xfer) issue_cnt <= issue_cnt + 3'd1;
                if (ack_take) ack_cnt   <= ack_cnt + 3'd1;
            end
            if (ack_take) line_q[ack_row] <= ack_data[DW-1:0];
        end
    end

endmodule

// File: tb/tb_dc_1_bank_requester.sv
// Scoreboard bench for dc_1_bank_requester: expected requests/responses are
// queued at issue time, a negedge monitor pops and compares on each transfer.
`ifndef WAY_BITS
`define WAY_BITS 2
`endif

module tb_dc_1_bank_requester;
    localparam int WB  = `WAY_BITS;
    localparam int RQW = 1 + WB + 29 + 2 + 36;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid, cmd_retry, cmd_write;
    logic [28:0]   cmd_addr;
    logic [WB-1:0] cmd_way;
    logic [127:0]  cmd_wdata;
    logic [15:0]   cmd_wmask;
    logic          req_valid, req_retry, write;
    logic [28:0]   req_addr;
    logic [WB-1:0] way_no;
    logic [1:0]    row_even_odd;
    logic [35:0]   req_data;
    logic          ack_valid, ack_retry;
    logic [35:0]   ack_data;
    logic          rsp_valid, rsp_retry;
    logic [127:0]  rsp_data;

    dc_1_bank_requester dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_retry(cmd_retry), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_way(cmd_way), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .req_valid(req_valid), .req_retry(req_retry), .write(write), .req_addr(req_addr),
        .way_no(way_no), .row_even_odd(row_even_odd), .req_data(req_data),
        .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_data(ack_data),
        .rsp_valid(rsp_valid), .rsp_retry(rsp_retry), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [RQW-1:0] exp_req_q[$];
    logic [127:0]   exp_rsp_q[$];
    logic [35:0]    bank_data_q[$];
    logic [35:0]    pend_data_q[$];
    int             pend_due_q[$];
    int             mode = 0, ack_extra_max = 0, spur = 0, st_req = 3, st_rsp = 5;
    int             req_seen = 0, last_rsp_cyc = 0;
    logic [127:0]   last_rsp = '0;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [28:0] a, input logic [WB-1:0] w,
                            input int row, input logic [35:0] d);
        exp_req_q.push_back({wr, w, a, 2'(row), d});
    endtask

    // Reference model: one request per row, row payload from the matching mask/data slice.
    task automatic push_cmd(input logic wr, input logic [28:0] a, input logic [WB-1:0] w,
                            input logic [127:0] wd, input logic [15:0] wm,
                            input logic [3:0][35:0] wds);
        logic [127:0] line;
        line = '0;
        for (int r = 0; r < 4; r++) begin
            push_req(wr, a, w, r, wr ? {wm[4*r +: 4], wd[32*r +: 32]} : 36'h0);
            if (!wr) begin
                bank_data_q.push_back(wds[r]);
                line[32*r +: 32] = wds[r][31:0];
            end
        end
        if (!wr) begin
            exp_rsp_q.push_back(line);
            last_rsp = line;
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [28:0] a, input logic [WB-1:0] w,
                            input logic [127:0] wd, input logic [15:0] wm, output int c0);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_way = w;
        cmd_wdata = wd; cmd_wmask = wm;
        @(negedge clk);
        while (cmd_retry === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cmd_retry !== 1'b0) check("cmd_accept_timeout", 1, 0);
        c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = '0; cmd_wmask = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((exp_req_q.size() != 0 || exp_rsp_q.size() != 0 || pend_due_q.size() != 0 ||
                cmd_retry !== 1'b0 || spur != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("done_timeout", 1, 0);
    endtask

    // Monitor: scoreboard pops, stall stability and busy checks.
    logic           stall_req = 1'b0, stall_rsp = 1'b0;
    logic [RQW-1:0] held_req;
    logic [127:0]   held_rsp;
    logic [RQW-1:0] cur_req;
    assign cur_req = {write, way_no, req_addr, row_even_odd, req_data};

    always @(negedge clk) begin
        if (!reset) begin
            stall_req <= 1'b0;
            stall_rsp <= 1'b0;
        end else begin
            if (req_valid || rsp_valid) check("cmd_retry_busy", cmd_retry, 1);
            if (stall_req) check("req_hold", {req_valid, cur_req}, {1'b1, held_req});
            if (stall_rsp) begin
                check("rsp_valid_hold", rsp_valid, 1);
                check("rsp_data_hold", rsp_data, held_rsp);
            end
            if (req_valid && !req_retry) begin
                req_seen++;
                if (exp_req_q.size() == 0) check("req_unexpected", cur_req, 0);
                else check("req", cur_req, exp_req_q.pop_front());
                if (!write && bank_data_q.size() != 0) begin
                    pend_data_q.push_back(bank_data_q.pop_front());
                    pend_due_q.push_back(cyc + 1 + $urandom_range(0, ack_extra_max));
                end
            end
            if (rsp_valid && !rsp_retry) begin
                last_rsp_cyc = cyc;
                if (exp_rsp_q.size() == 0) check("rsp_unexpected", rsp_data, 0);
                else check("rsp", rsp_data, exp_rsp_q.pop_front());
            end
            stall_req <= req_valid && req_retry;
            stall_rsp <= rsp_valid && rsp_retry;
            held_req  <= cur_req;
            held_rsp  <= rsp_data;
        end
    end

    // Bank model: in-order acks after the queued delay, plus optional spurious acks.
    initial begin
        ack_valid = 1'b0; ack_data = '0;
        forever begin
            @(posedge clk); #1;
            ack_valid = 1'b0; ack_data = '0;
            if (pend_due_q.size() != 0) begin
                if (pend_due_q[0] <= cyc) begin
                    ack_valid = 1'b1;
                    ack_data  = pend_data_q.pop_front();
                    void'(pend_due_q.pop_front());
                end
            end else if (spur > 0) begin
                spur--;
                ack_valid = 1'b1;
                ack_data  = {4'($urandom), 32'($urandom)};
            end
        end
    end

    initial begin
        req_retry = 1'b0; rsp_retry = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                1: begin
                    req_retry = ($urandom_range(0, 3) == 0);
                    rsp_retry = ($urandom_range(0, 2) == 0);
                end
                2: begin
                    req_retry = req_valid && (row_even_odd == 2'd1) && (st_req < 3);
                    if (req_retry) st_req++;
                    rsp_retry = rsp_valid && (st_rsp < 5);
                    if (rsp_retry) st_rsp++;
                end
                default: begin
                    req_retry = 1'b0;
                    rsp_retry = 1'b0;
                end
            endcase
        end
    end

    initial begin : main
        logic [3:0][35:0] wds;
        logic [3:0][35:0] wconst;
        int c0, c1, n, base;
        logic wr;
        logic [28:0] a;
        logic [WB-1:0] w;
        logic [127:0] wd;
        logic [15:0] wm;

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_way = '0;
        cmd_wdata = '0; cmd_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {req_valid, write, rsp_valid, ack_retry, cmd_retry,
                             row_even_odd, way_no, req_addr, req_data}, 0);
        check("reset_rsp_data", rsp_data, 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("idle_cmd_retry", cmd_retry, 0);

        // Directed read with 1-cycle bank acks.
        for (int r = 0; r < 4; r++) wds[r] = 36'h0_1111_1111 * 36'(r + 1);
        push_cmd(1'b0, 29'h0000_07C0, 2, '0, '0, wds);
        void'(exp_rsp_q.pop_back());
        exp_rsp_q.push_back(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        send_cmd(1'b0, 29'h0000_07C0, 2, '0, '0, c0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("rd_latency", cyc - c0, 6);
        wait_done();

        // Directed write with spurious acks that must be ignored.
        wconst[0] = 36'h1_AAAA_AAAA; wconst[1] = 36'hF_BBBB_BBBB;
        wconst[2] = 36'h0_CCCC_CCCC; wconst[3] = 36'hF_DDDD_DDDD;
        for (int r = 0; r < 4; r++) push_req(1'b1, 29'h0000_0100, 1, r, wconst[r]);
        spur = 2;
        send_cmd(1'b1, 29'h0000_0100, 1, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA,
                 16'hF0F1, c0);
        n = 0;
        @(negedge clk);
        while (cmd_retry && n < 50) begin @(negedge clk); n++; end
        check("wr_latency", cyc - c0, 5);
        wait_done();
        check("rsp_data_after_write", rsp_data, last_rsp);

        // Spurious acks while idle.
        spur = 3;
        repeat (3) begin
            @(negedge clk);
            check("spur_idle", {ack_valid, req_valid, rsp_valid, cmd_retry, ack_retry}, 5'b10000);
        end
        wait_done();
        check("spur_rsp_data", rsp_data, last_rsp);
        for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
        push_cmd(1'b0, 29'h1234_5678, 3, '0, '0, wds);
        send_cmd(1'b0, 29'h1234_5678, 3, '0, '0, c0);
        wait_done();

        // Three-cycle request stall on row 1.
        mode = 2; st_req = 0; st_rsp = 5;
        base = req_seen;
        for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
        push_cmd(1'b0, 29'h0ABC_DEF0, 1, '0, '0, wds);
        send_cmd(1'b0, 29'h0ABC_DEF0, 1, '0, '0, c0);
        wait_done();
        check("stall_req_count", req_seen - base, 4);

        // Five-cycle response stall, next command pushed in behind it.
        st_req = 3; st_rsp = 0;
        for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
        push_cmd(1'b0, 29'h0000_0040, 0, '0, '0, wds);
        send_cmd(1'b0, 29'h0000_0040, 0, '0, '0, c0);
        push_cmd(1'b1, 29'h0000_0080, 2, {4{32'h5A5A_0F0F}}, 16'h3C96, wds);
        send_cmd(1'b1, 29'h0000_0080, 2, {4{32'h5A5A_0F0F}}, 16'h3C96, c1);
        check("cmd_after_rsp", c1 > last_rsp_cyc, 1);
        wait_done();
        mode = 0;

        // Reset pulse after the second request of a read.
        for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
        base = req_seen;
        push_cmd(1'b0, 29'h0F0F_0F0F, 2, '0, '0, wds);
        send_cmd(1'b0, 29'h0F0F_0F0F, 2, '0, '0, c0);
        n = 0;
        while (req_seen < base + 2 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("midreset_ctrl", {req_valid, write, rsp_valid, ack_retry, cmd_retry,
                                row_even_odd, way_no, req_addr, req_data}, 0);
        check("midreset_rsp_data", rsp_data, 0);
        exp_req_q.delete(); exp_rsp_q.delete(); bank_data_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);
        check("post_reset_idle", {req_valid, rsp_valid, cmd_retry}, 0);
        check("late_acks_ignored", rsp_data, 0);
        for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
        push_cmd(1'b0, 29'h1555_0001, 1, '0, '0, wds);
        send_cmd(1'b0, 29'h1555_0001, 1, '0, '0, c0);
        wait_done();

        // Randomized traffic with random stalls and ack delays.
        mode = 1; ack_extra_max = 3;
        for (int i = 0; i < 40; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            a  = 29'($urandom);
            w  = WB'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            wm = 16'($urandom);
            for (int r = 0; r < 4; r++) wds[r] = {4'($urandom), 32'($urandom)};
            if (wr) begin
                wait_done();
                spur = $urandom_range(0, 2);
            end
            push_cmd(wr, a, w, wd, wm, wds);
            send_cmd(wr, a, w, wd, wm, c0);
        end
        wait_done();
        mode = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dc_1_bank_requester.md
DC_1_BANK_REQUESTER -- requirements
Module: dc_1_bank_requester

Interface
REQ-001 Parameter: Width, 36, bank word width: 4-bit byte mask in [35:32], 32-bit data in [31:0].
REQ-002 Parameter: Rows, 4, rows per line per way; row index is 2 bits.
REQ-003 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port: reset, input, 1, asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-005 Ports, command side:
- cmd_valid, input, 1.
- cmd_retry, output, 1.
- cmd_write, input, 1.
- cmd_addr, input, 29, logical address.
- cmd_way, input, `WAY_BITS.
- cmd_wdata, input, 128.
- cmd_wmask, input, 16.
REQ-006 Ports, bank side:
- req_valid, output, 1.
- req_retry, input, 1.
- write, output, 1.
- req_addr, output, 29.
- way_no, output, `WAY_BITS.
- row_even_odd, output, 2.
- req_data, output, 36.
- ack_valid, input, 1.
- ack_retry, output, 1.
- ack_data, input, 36.
REQ-007 Ports, response side:
- rsp_valid, output, 1.
- rsp_retry, input, 1.
- rsp_data, output, 128.

Function
REQ-008 Handshakes: a transfer occurs on an edge where valid=1 and retry=0; a valid SHALL hold with stable payload until transferred.
REQ-009 States: IDLE, ISSUE, DRAIN, RESP.
REQ-010 IDLE: cmd_retry=0; on a cmd transfer, latch addr, way, write, wdata, wmask; clear issue_cnt and ack_cnt; go to ISSUE.
REQ-011 cmd_retry SHALL be 1 in every state other than IDLE.
REQ-012 ISSUE: req_valid=1, row_even_odd=issue_cnt, req_addr=latched addr, way_no=latched way, write=latched write.
- issue_cnt increments on each req transfer.
- When req_retry=1, all req outputs hold.
REQ-013 Write req_data for row r: {wmask[4r+3:4r], wdata[32r+31:32r]}. Read req_data: 36'h0.
REQ-014 After the transfer with issue_cnt=Rows-1:
- write: go to IDLE; writes produce no ack and no response.
- read: go to DRAIN if ack_cnt+acks this cycle < Rows, else RESP.
REQ-015 Read acks arrive in request order.
- In ISSUE and DRAIN, ack_retry=0; each ack_valid stores ack_data[31:0] into line buffer slot ack_cnt (bits 32*ack_cnt+31:32*ack_cnt), then ack_cnt increments.
- An ack may coincide with a req transfer in the same cycle; both SHALL be counted.
REQ-016 DRAIN: on the ack with ack_cnt=Rows-1, go to RESP.
REQ-017 RESP: rsp_valid=1, rsp_data=line buffer, ack_retry=1; on rsp transfer go to IDLE.
REQ-018 Cannot-reach-IDLE limits:
- At most Rows read requests are outstanding.
- issue_cnt and ack_cnt are 3 bits and never exceed Rows.
REQ-019 An ack_valid in IDLE, or during a write command, SHALL be ignored with ack_retry=0; no state, counter or buffer change.
REQ-020 Outputs req_valid, rsp_valid and cmd_retry SHALL be registered or pure functions of state; none depends combinationally on ack_valid.
REQ-021 Latency, read, no stalls:
- cmd transfer at cycle 0; requests at cycles 1-4.
- With 1-cycle bank ack, rsp_valid at cycle 6.
REQ-022 Latency, write, no stalls: requests at cycles 1-4; cmd_retry=0 again at cycle 5.

Reset
REQ-023 While reset=0:
- State IDLE; issue_cnt and ack_cnt 0; line buffer 0.
- req_valid=0, write=0, rsp_valid=0, ack_retry=0, cmd_retry=0.
- req_data=0, req_addr=0, way_no=0, row_even_odd=0, rsp_data=0.
REQ-024 Reset asserted mid-command SHALL abandon it: no further req or rsp, and acks arriving after release are ignored per REQ-019.

Verification
REQ-025 Read, addr=29'h0000_07C0, way=2, bank acks 1 cycle later with data 36'h0_1111_1111 * (r+1):
- Requests carry row_even_odd 0,1,2,3.
- rsp_data=128'h4444_4444_3333_3333_2222_2222_1111_1111.
REQ-026 Write, wdata=128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, wmask=16'hF0F1, way=1:
- req_data per row is 36'h1_AAAA_AAAA, 36'hF_BBBB_BBBB, 36'h0_CCCC_CCCC, 36'hF_DDDD_DDDD.
- write=1 on all four; no rsp_valid; IDLE at cycle 5.
REQ-027 Read with req_retry=1 for 3 cycles on row 1:
- Row-1 outputs held stable throughout the stall.
- Exactly 4 request transfers; response correct.
REQ-028 Read with rsp_retry=1 for 5 cycles:
- rsp_valid and rsp_data held; cmd_retry=1 throughout.
- A new cmd is accepted only after the rsp transfer.
REQ-029 reset=0 pulsed after the 2nd read request is accepted:
- All outputs take reset values immediately.
- Late acks ignored; a following read completes with correct data.
REQ-030 Spurious ack_valid while IDLE: no state change, ack_retry=0, next read rsp_data unaffected.
